coeff_packer: RTL

COEFF_PACKER -- requirements
Module: coeff_packer

---
 rtl/coeff_packer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/coeff_packer.sv
// coeff_packer: packs a stream of w-bit polynomial coefficients (w = 11..13,
// chosen by poly_q) LSB-first into 32-bit output words.
//
// Ports
//   clk        single clock, rising edge
//   resetn     synchronous reset, active HIGH (legacy name)
//   poly_n     coefficient count n, captured while resetn=1
//   poly_q     modulus select (w = 11 + poly_q, 3 -> 13), captured while resetn=1
//   in_coeff   coefficient, reduced mod q by truncation to w bits
//   in_valid   / in_ready   input handshake
//   out_word   packed word, valid when out_valid
//   out_valid  / out_ready  output handshake
//   out_last   final word of the polynomial
//   done       sticky completion flag (last word consumed)
module coeff_packer #(
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [9:0]       poly_n,
  input  logic [1:0]       poly_q,
  input  logic [12:0]      in_coeff,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done
);

  typedef enum logic [1:0] {PACK, FLUSH, DONE} state_t;

  state_t      state, state_nxt;
  logic [43:0] bbuf;
  logic [5:0]  fill;
  logic [9:0]  cnt, n_r;
  logic [1:0]  q_r;
  logic [31:0] word_r;
  logic        vld_r, last_r;

  logic [3:0]  w;
  logic [12:0] cmask;
  logic        slot, emit, pad, rdy, acc;
  logic [43:0] buf_s, buf_n;
  logic [5:0]  fill_s, fill_n;

  always_comb begin
    w     = (q_r == 2'd3) ? 4'd13 : 4'd11 + {2'b00, q_r};
    // 1<<13 wraps to 0 in 13 bits, so the w=13 mask is all ones
    cmask = in_coeff & ((13'd1 << w) - 13'd1);
    slot  = !vld_r || out_ready;
    emit  = (state != DONE) && (fill >= 6'd32) && slot;
    // final partial word in FLUSH, zero padded (upper buffer bits are already 0)
    pad   = (state == FLUSH) && (fill != 6'd0) && (fill < 6'd32) && slot;
    rdy   = (state == PACK) && (cnt < n_r) && ((fill < 6'd32) || emit);
    acc   = in_valid && rdy;
    buf_s  = emit ? {32'b0, bbuf[43:32]} : bbuf;
    fill_s = emit ? fill - 6'd32 : fill;
    // fill_s < 32 whenever acc, so the new coefficient ends at bit <= 43
    buf_n  = acc ? (buf_s | ({31'b0, cmask} << fill_s)) : buf_s;
    fill_n = acc ? fill_s + {2'b00, w} : fill_s;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      PACK: begin
        if (n_r == 10'd0)                         state_nxt = DONE;
        else if (acc && (cnt == n_r - 10'd1))     state_nxt = FLUSH;
      end
      FLUSH: if (vld_r && out_ready && last_r)    state_nxt = DONE;
      default:                                    state_nxt = DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state  <= PACK;
      bbuf   <= '0;
      fill   <= '0;
      cnt    <= '0;
      word_r <= '0;
      vld_r  <= 1'b0;
      last_r <= 1'b0;
      n_r    <= poly_n;
      q_r    <= poly_q;
    end else begin
      state <= state_nxt;
      if (acc) cnt <= cnt + 10'd1;
      if (pad) begin
        bbuf   <= '0;
        fill   <= '0;
        word_r <= bbuf[31:0];
        vld_r  <= 1'b1;
        last_r <= 1'b1;
      end else begin
        bbuf <= buf_n;
        fill <= fill_n;
        if (emit) begin
          word_r <= bbuf[31:0];
          vld_r  <= 1'b1;
          // in FLUSH nothing more arrives: an emit leaving fill=0 ends the stream
          last_r <= (state == FLUSH) && (fill == 6'd32);
        end else if (out_ready) begin
          vld_r  <= 1'b0;
        end
      end
    end
  end

  // outputs forced low for the whole reset cycle, not just after its edge
  always_comb begin
    in_ready  = rdy && !resetn;
    out_valid = vld_r && !resetn;
    out_last  = last_r && !resetn;
    out_word  = resetn ? '0 : OUT_W'(word_r);
    done      = (state == DONE) && !resetn;
  end

endmodule
